// File: rtl/tsc_param_cache_pkg.sv
// tsc_param_cache_pkg: state and trigger-mode codes plus the trigger comparator,
// shared by the cache RTL and its benches.
package tsc_param_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4,
        ST_LOAD  = 3'd5,
        ST_SEND  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TM_RISE  = 2'b00,
        TM_FALL  = 2'b01,
        TM_LEVEL = 2'b10,
        TM_FORCE = 2'b11
    } trig_mode_e;

    // prev_ge/cur_ge are the threshold compares of the last stored and current sample
    function automatic logic trig_hit(input trig_mode_e mode, input logic prev_ge, input logic cur_ge);
        return mode == TM_RISE  ? !prev_ge && cur_ge :
               mode == TM_FALL  ? prev_ge && !cur_ge :
               mode == TM_LEVEL ? cur_ge : 1'b1;
    endfunction

endpackage

// File: rtl/tsc_param_cache_ring_ram.sv
// tsc_param_cache_ring_ram: DEPTH x DATA_W sample ring, one write port and one
// registered read port; DEPTH need not be a power of two.
module tsc_param_cache_ring_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 33,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/tsc_param_cache.sv
// tsc_param_cache: trigger-surround capture of ADC samples into a ring, frozen
// around a trigger and streamed out oldest-first over a valid/ready readout.
module tsc_param_cache
    import tsc_param_cache_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRE_DEPTH  = 16,
    parameter int POST_DEPTH = 16,
    parameter int TIME_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] threshold,
    input  logic [1:0]        trig_mode,
    input  logic              sbf,
    input  logic              req,
    output logic              trd,
    output logic              cd,
    output logic [TIME_W-1:0] trigtm,
    output logic              rdy,
    output logic [DATA_W-1:0] dat,
    output logic              sd,
    output logic [2:0]        current_state
);

    localparam int DEPTH = PRE_DEPTH + 1 + POST_DEPTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_ptr_q, trig_ptr_d;
    logic [DATA_W-1:0] prev_q, prev_d, ram_rdata;
    logic [TIME_W-1:0] timer_q, trigtm_q, trigtm_d;
    logic              trd_q, trd_d, sd_q, sd_d;
    logic              wr_en, hit, xfer, last_xfer, start_ok;
    logic [PTR_W:0]    win_sum;
    logic [PTR_W-1:0]  win_start;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign wr_en     = adc_valid && (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST);
    assign hit       = state_q == ST_ARMED && adc_valid &&
                       trig_hit(trig_mode_e'(trig_mode), prev_q >= threshold, adc_data >= threshold);
    assign xfer      = state_q == ST_SEND && req;
    assign last_xfer = xfer && cnt_q == CNT_W'(DEPTH - 1);
    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    // oldest window sample sits PRE_DEPTH behind the trigger, i.e. POST_DEPTH+1 ahead mod DEPTH
    assign win_sum   = {1'b0, trig_ptr_q} + (PTR_W + 1)'(POST_DEPTH + 1);
    assign win_start = win_sum >= (PTR_W + 1)'(DEPTH) ? PTR_W'(win_sum - (PTR_W + 1)'(DEPTH)) : PTR_W'(win_sum);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start_ok ? ST_FILL : ST_IDLE;
            ST_FILL:  state_d = wr_en && cnt_q == CNT_W'(PRE_DEPTH - 1) ? ST_ARMED : ST_FILL;
            ST_ARMED: state_d = !hit ? ST_ARMED : POST_DEPTH == 0 ? ST_DONE : ST_POST;
            ST_POST:  state_d = wr_en && cnt_q == CNT_W'(POST_DEPTH == 0 ? 0 : POST_DEPTH - 1) ? ST_DONE : ST_POST;
            ST_DONE:  state_d = start_ok ? ST_FILL : sbf ? ST_LOAD : ST_DONE;
            ST_LOAD:  state_d = ST_SEND;
            ST_SEND:  state_d = last_xfer ? ST_IDLE : ST_SEND;
            default:  state_d = ST_IDLE;
        endcase
        cnt_d      = state_d != state_q ? '0 :
                     (wr_en && state_q != ST_ARMED) || xfer ? cnt_q + 1'b1 : cnt_q;
        wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        // read one ahead on each transfer so dat is ready the very next cycle
        rd_ptr_d   = state_q == ST_LOAD ? win_start : xfer ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        trig_ptr_d = hit ? wr_ptr_q : trig_ptr_q;
        prev_d     = wr_en ? adc_data : prev_q;
        trigtm_d   = hit ? timer_q : trigtm_q;
        trd_d      = hit;
        sd_d       = last_xfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            trig_ptr_q <= '0;
            prev_q     <= '0;
            timer_q    <= '0;
            trigtm_q   <= '0;
            trd_q      <= 1'b0;
            sd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            prev_q     <= prev_d;
            timer_q    <= timer_q + 1'b1;
            trigtm_q   <= trigtm_d;
            trd_q      <= trd_d;
            sd_q       <= sd_d;
        end
    end

    tsc_param_cache_ring_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (adc_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign trd           = trd_q;
    assign cd            = state_q == ST_DONE || state_q == ST_LOAD || state_q == ST_SEND;
    assign trigtm        = trigtm_q;
    assign rdy           = state_q == ST_SEND;
    assign dat           = rdy ? ram_rdata : '0;
    assign sd            = sd_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_tsc_param_cache.sv
// tb_tsc_param_cache: directed vectors for the trigger-surround cache with
// PRE_DEPTH=4, POST_DEPTH=3 (window of 8) and threshold 8'h80.
module tb_tsc_param_cache;

    logic        clk = 1'b0;
    logic        reset, start, adc_valid, sbf, req;
    logic [7:0]  adc_data, threshold, dat;
    logic [1:0]  trig_mode;
    logic        trd, cd, rdy, sd;
    logic [31:0] trigtm, tb_time, exp_tm;
    logic [2:0]  current_state;
    logic [7:0]  exp_win [8];
    int          checks = 0;
    int          failures = 0;

    tsc_param_cache #(.DATA_W(8), .PRE_DEPTH(4), .POST_DEPTH(3), .TIME_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .threshold     (threshold),
        .trig_mode     (trig_mode),
        .sbf           (sbf),
        .req           (req),
        .trd           (trd),
        .cd            (cd),
        .trigtm        (trigtm),
        .rdy           (rdy),
        .dat           (dat),
        .sd            (sd),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    // reference timer: cleared by reset, +1 per clock
    always @(posedge clk) tb_time <= reset ? 32'd0 : tb_time + 32'd1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic samp(input logic [7:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic trig_samp(input logic [7:0] d);
        exp_tm = tb_time;
        samp(d);
        chk("trd_hit", trd, 1);
        chk("trigtm", trigtm, exp_tm);
    endtask

    task automatic read_win(input bit toggle);
        int n = 0;
        int k = 0;
        logic [7:0] hold;
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        chk("load_state", current_state, 5);
        tick();
        chk("send_state", current_state, 6);
        while (n < 8 && k < 64) begin
            req = !toggle || (k % 4 == 0) || (k % 4 == 3);
            chk("rdy", rdy, 1);
            if (req) chk($sformatf("dat%0d", n), dat, exp_win[n]);
            hold = dat;
            tick();
            k++;
            if (req) n++;
            else chk("dat_hold", dat, hold);
        end
        req = 1'b0;
        chk("xfers", n, 8);
        chk("sd_end", sd, 1);
        chk("rdy_end", rdy, 0);
        chk("cd_end", cd, 0);
        chk("state_end", current_state, 0);
        tick();
        chk("sd_pulse", sd, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; adc_valid = 1'b0; sbf = 1'b0; req = 1'b0;
        adc_data = '0; threshold = 8'h80; trig_mode = 2'b00;
        tick();
        tick();
        chk("rst_state", current_state, 0);
        chk("rst_trd", trd, 0);
        chk("rst_cd", cd, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_dat", dat, 0);
        chk("rst_sd", sd, 0);
        chk("rst_trigtm", trigtm, 0);
        reset = 1'b0;

        // rising ramp, continuous readout
        arm();
        chk("fill_state", current_state, 1);
        samp(8'h10); samp(8'h20); samp(8'h30); samp(8'h40);
        chk("armed_state", current_state, 2);
        samp(8'h50); samp(8'h60); samp(8'h70);
        chk("rise_quiet", trd, 0);
        trig_samp(8'h90);
        chk("post_state", current_state, 3);
        samp(8'hA0);
        chk("trd_pulse", trd, 0);
        samp(8'hB0); samp(8'hC0);
        chk("done_state", current_state, 4);
        chk("cd_done", cd, 1);
        exp_win = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0};
        read_win(1'b0);

        // crossing inside FILL is ignored; stray commands ignored in ARMED
        arm();
        samp(8'h70);
        chk("fill_no_trd0", trd, 0);
        samp(8'h90);
        chk("fill_no_trd1", trd, 0);
        samp(8'h91); samp(8'h92);
        chk("armed2_state", current_state, 2);
        sbf = 1'b1; tick(); sbf = 1'b0;
        chk("sbf_ignored", current_state, 2);
        arm();
        chk("start_ignored", current_state, 2);
        adc_data = 8'hFF; tick();
        chk("invalid_quiet", trd, 0);
        samp(8'h70);
        chk("rise_on_fall_quiet", trd, 0);
        trig_samp(8'h90);
        samp(8'h01); samp(8'h02); samp(8'h03);
        chk("done2_state", current_state, 4);
        arm();
        chk("restart_state", current_state, 1);
        chk("restart_cd", cd, 0);

        // falling
        trig_mode = 2'b01;
        samp(8'h90); samp(8'h90); samp(8'h90); samp(8'h70);
        samp(8'h90);
        chk("fall_on_rise_quiet", trd, 0);
        trig_samp(8'h70);
        samp(8'h01); samp(8'h02); samp(8'h03);
        arm();

        // level
        trig_mode = 2'b10;
        samp(8'h10); samp(8'h10); samp(8'h10); samp(8'h10);
        samp(8'h7F);
        chk("level_quiet", trd, 0);
        trig_samp(8'h85);
        samp(8'h01); samp(8'h02); samp(8'h03);
        arm();

        // force
        trig_mode = 2'b11;
        samp(8'h01); samp(8'h02); samp(8'h03); samp(8'h04);
        chk("force_armed", current_state, 2);
        trig_samp(8'h05);
        chk("force_post", current_state, 3);
        samp(8'h01); samp(8'h02); samp(8'h03);
        chk("force_done", current_state, 4);
        arm();

        // 21 samples before trigger with valid gaps, readout with req toggling
        trig_mode = 2'b00;
        for (int i = 1; i <= 21; i++) begin
            samp(8'(i));
            if (i == 10) begin tick(); tick(); end
        end
        chk("wrap_quiet", trd, 0);
        chk("wrap_armed", current_state, 2);
        trig_samp(8'h90);
        samp(8'hC1); tick(); samp(8'hC2); samp(8'hC3);
        chk("wrap_done", current_state, 4);
        exp_win = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h90, 8'hC1, 8'hC2, 8'hC3};
        read_win(1'b1);

        // reset in POST
        trig_mode = 2'b11;
        arm();
        samp(8'h01); samp(8'h02); samp(8'h03); samp(8'h04);
        trig_samp(8'h07);
        chk("rp_post", current_state, 3);
        reset = 1'b1; tick();
        chk("rp_state", current_state, 0);
        chk("rp_trd", trd, 0);
        chk("rp_trigtm", trigtm, 0);
        chk("rp_cd", cd, 0);
        reset = 1'b0;

        // reset in SEND
        arm();
        samp(8'h01); samp(8'h02); samp(8'h03); samp(8'h04);
        trig_samp(8'h07);
        samp(8'h08); samp(8'h09); samp(8'h0A);
        sbf = 1'b1; tick(); sbf = 1'b0;
        tick();
        chk("rs_send", current_state, 6);
        chk("rs_dat0", dat, 8'h01);
        req = 1'b1; tick(); req = 1'b0;
        chk("rs_dat1", dat, 8'h02);
        reset = 1'b1; tick();
        chk("rs_state", current_state, 0);
        chk("rs_rdy", rdy, 0);
        chk("rs_dat", dat, 0);
        chk("rs_cd", cd, 0);
        chk("rs_trigtm", trigtm, 0);
        reset = 1'b0;
        tick();
        chk("rs_sd", sd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
